// File: rtl/present_inv_key_schedule.sv
// present_inv_key_schedule
//   Decryption-side round-key generator for PRESENT-80. The master key is
//   walked forward to K32 one step per clock. The round keys are then handed
//   out in reverse order (K32 down to K1), undoing one forward step per
//   accepted key. All outputs are decoded from registered state only.
module present_inv_key_schedule #(
  parameter int KEY_W  = 80,
  parameter int RK_W   = 64,
  parameter int ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_key_in,
  output logic             o_busy,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic [RK_W-1:0]  o_round_key,
  output logic [5:0]       o_round_idx,
  output logic             o_done
);

  localparam logic [5:0] LP_FIRST_IDX = ROUNDS[5:0];
  localparam logic [4:0] LP_LAST_CNT  = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [79:0]      r_key;
  logic [79:0]      w_key_nxt;
  logic [4:0]       r_cnt;
  logic [4:0]       w_cnt_nxt;
  logic [5:0]       r_idx;
  logic [5:0]       w_idx_nxt;
  logic [5:0]       w_idx_dec;
  logic             w_xfer;

  // PRESENT S-box
  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Inverse PRESENT S-box
  function automatic logic [3:0] f_sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Forward key-schedule step: rotate left 61, S-box top nibble, add round counter
  function automatic logic [79:0] f_fwd(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = f_sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ i;
    return t;
  endfunction

  // Exact inverse of f_fwd for the same counter value
  function automatic logic [79:0] f_inv(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ i;
    t[79:76]   = f_sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  assign w_xfer    = (r_state == ST_EMIT) && i_rk_ready;
  assign w_idx_dec = r_idx - 6'd1;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_key   <= 80'd0;
      r_cnt   <= 5'd0;
      r_idx   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_key_nxt   = i_key_in;
          w_cnt_nxt   = 5'd1;
          w_state_nxt = ST_FWD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FWD: begin
        w_key_nxt = f_fwd(r_key, r_cnt);
        if (r_cnt == LP_LAST_CNT) begin
          w_idx_nxt   = LP_FIRST_IDX;
          w_state_nxt = ST_EMIT;
        end else begin
          w_cnt_nxt   = r_cnt + 5'd1;
        end
      end
      ST_EMIT: begin
        if (w_xfer && (r_idx > 6'd1)) begin
          w_key_nxt = f_inv(r_key, w_idx_dec[4:0]);
          w_idx_nxt = w_idx_dec;
        end else if (w_xfer) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; key/index forced to zero when not valid
  always_comb begin
    o_busy      = 1'b0;
    o_rk_valid  = 1'b0;
    o_done      = 1'b0;
    o_round_key = {RK_W{1'b0}};
    o_round_idx = 6'd0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
      end
      ST_FWD: begin
        o_busy = 1'b1;
      end
      ST_EMIT: begin
        o_busy      = 1'b1;
        o_rk_valid  = 1'b1;
        o_round_key = r_key[79:16];
        o_round_idx = r_idx;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule
